axi_slave_memory: RTL and testbench
===================================

Name: axi_slave_memory

Overview:
Synthesizable AXI4 responder (slave) memory: the far end of the AXI master port driven by memory_controller. It accepts INCR read/write bursts on the AW/W/B and AR/R channels, backed by an on-chip word RAM. It replaces the behavioural slave BFM in synthesizable system builds and also serves as a deterministic bench target. Read and write channels run as independent state machines sharing one RAM.

Parameters:
C_AXI_DATA_WIDTH, 32, data bus width; fixed at 32, one word per beat.
C_OFFSET_WIDTH, 12, number of byte-address bits decoded; RAM depth = 2^(C_OFFSET_WIDTH-2) words; upper address bits ignored.
READ_WAIT, 0, extra cycles inserted between AR acceptance and the first RVALID (0..255).

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESETN  in  1  asynchronous, active-low reset.
AWADDR  in  32  write burst start byte address.
AWLEN  in  8  write beats minus 1.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address accepted.
WDATA  in  32  write data.
WSTRB  in  4  byte enables; bit i writes WDATA[8i+7:8i].
WLAST  in  1  master's last-beat flag.
WVALID  in  1  write data valid.
WREADY  out  1  write data accepted.
BRESP  out  2  00 OKAY, 10 SLVERR.
BVALID  out  1  write response valid.
BREADY  in  1  response accepted.
ARADDR  in  32  read burst start byte address.
ARLEN  in  8  read beats minus 1.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address accepted.
RDATA  out  32  read data.
RRESP  out  2  always 00.
RLAST  out  1  final read beat.
RVALID  out  1  read data valid.
RREADY  in  1  read data accepted.

Behaviour:
- Reset (ARESETN low, async): both FSMs to IDLE; all outputs 0; counters 0. RAM contents not reset. AWREADY/ARREADY rise on the first ACLK edge after ARESETN releases.
- Handshake: transfer occurs on a rising edge with VALID&READY both high. Outputs are registered; VALID, once asserted, holds with stable payload until accepted.
- Word index = addr[C_OFFSET_WIDTH-1:2]. It increments by 1 per beat and wraps modulo RAM depth. addr[1:0] is ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch index and beat count = AWLEN; clear the error flag; go to W_DATA (AWREADY=0, WREADY=1 next cycle).
  - W_DATA: each W handshake writes RAM bytes per WSTRB at the current index, then increments the index. On the beat where count==0, go to W_RESP with WREADY=0.
  - Error flag: set if WLAST=1 on a non-final beat or WLAST=0 on the final beat. The burst always ends on the count, never on WLAST.
  - W_RESP: BVALID=1, BRESP = error ? 10 : 00. On BREADY go to W_IDLE with AWREADY=1 the next cycle.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch index and count = ARLEN; load the wait counter with READ_WAIT; go to R_WAIT.
  - R_WAIT: decrement the wait counter. When it is 0, present the RAM word at the index: RVALID=1, RLAST=(count==0), and go to R_DATA.
  - Minimum latency, AR handshake to RVALID: 2 cycles with READ_WAIT=0 (1 cycle synchronous RAM read plus output register). READ_WAIT adds that many cycles.
  - R_DATA: on R handshake, if RLAST go to R_IDLE with RVALID=0. Otherwise advance the index and present the next word in the following cycle. RVALID may drop for one cycle between beats for the RAM read. While RREADY=0, hold RDATA/RLAST.
- Simultaneous read and write to the same word in one cycle: read returns the old data (read-first). The write is visible to any later read.
- AW and AR accepted in the same cycle: both proceed independently.
- ARESETN asserted mid-burst: the burst is abandoned immediately, with no B or R completion. RAM words already written stay written.

Decomposition:
- Package axi_slave_defs: RESP_OKAY=2'b00, RESP_SLVERR=2'b10; write-state and read-state localparam encodings; WORD_BYTES=4.
- One sub-module, axi_slave_ram: 1 write port with 4-bit byte enables, 1 synchronous read port, read-first, depth 2^(C_OFFSET_WIDTH-2).
- FSMs and counters live in axi_slave_memory.

Test Plan:
1. Write AWADDR=0x100, AWLEN=0, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1 -> BVALID, BRESP=00. Then ARADDR=0x100, ARLEN=0 -> RDATA=0xDEADBEEF, RLAST=1, RVALID exactly 2 cycles after AR handshake.
2. Burst write AWADDR=0x200, AWLEN=3, data 1,2,3,4 -> read ARLEN=3 returns 1,2,3,4 with RLAST only on beat 4. With RREADY toggling 1,0,1,0, data holds while stalled.
3. Word 0x300 = 0xFFFFFFFF, then write 0x12345678 with WSTRB=0101 -> read 0xFF34FF78.
4. AWLEN=1 with WLAST=1 on beat 0 -> both beats written, BRESP=10. Next burst with correct WLAST -> BRESP=00.
5. C_OFFSET_WIDTH=12: burst write at 0xFFC, AWLEN=1 -> second beat lands at word 0 (read 0x000 returns it).
6. Drop ARESETN during beat 2 of a 4-beat read -> RVALID, ARREADY, AWREADY, BVALID all 0 immediately. After release, ARREADY=1 on the first edge and a new read of 0x100 returns 0xDEADBEEF.

Source files
------------

// File: rtl/axi_slave_memory_pkg.sv
// Shared response codes, beat geometry and FSM state types for the AXI4 responder memory.
package axi_slave_defs;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam int unsigned WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    // R_READ is the one-cycle slot in which the synchronous RAM output becomes valid.
    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_READ,
        R_DATA
    } rstate_e;

endpackage

// File: rtl/axi_slave_memory_ram.sv
// Word RAM with byte-enabled write port and registered read-first read port.
module axi_slave_ram
    import axi_slave_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [WORD_BYTES-1:0]   wstrb,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < WORD_BYTES; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_memory.sv
// AXI4 INCR-burst responder backed by an on-chip word RAM; read and write channels are independent FSMs.
module axi_slave_memory
    import axi_slave_defs::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_OFFSET_WIDTH   = 12,
    parameter int unsigned READ_WAIT        = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [31:0]                   AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [3:0]                    WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [31:0]                   ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int unsigned IW = C_OFFSET_WIDTH - 2;

    wstate_e                      w_state_q, w_state_d;
    logic [IW-1:0]                w_idx_q, w_idx_d;
    logic [7:0]                   w_cnt_q, w_cnt_d;
    logic                         w_err_q, w_err_d;
    logic                         awready_q, awready_d;
    logic                         wready_q, wready_d;
    logic                         bvalid_q, bvalid_d;
    logic [1:0]                   bresp_q, bresp_d;

    rstate_e                      r_state_q, r_state_d;
    logic [IW-1:0]                r_idx_q, r_idx_d;
    logic [7:0]                   r_cnt_q, r_cnt_d;
    logic [7:0]                   r_wait_q, r_wait_d;
    logic                         arready_q, arready_d;
    logic                         rvalid_q, rvalid_d;
    logic                         rlast_q, rlast_d;
    logic [C_AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;

    logic                         ram_we;
    logic [C_AXI_DATA_WIDTH-1:0]  ram_rdata;
    logic                         unused_addr_bits;

    assign unused_addr_bits = ^{AWADDR[31:C_OFFSET_WIDTH], AWADDR[1:0],
                                ARADDR[31:C_OFFSET_WIDTH], ARADDR[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        ram_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: if (AWVALID && awready_q) begin
                w_idx_d   = AWADDR[C_OFFSET_WIDTH-1:2];
                w_cnt_d   = AWLEN;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (WVALID && wready_q) begin
                ram_we  = 1'b1;
                w_idx_d = w_idx_q + 1'b1;
                if (WLAST != (w_cnt_q == 8'd0)) w_err_d = 1'b1;
                if (w_cnt_q == 8'd0) w_state_d = W_RESP;
                else                 w_cnt_d   = w_cnt_q - 8'd1;
            end
            W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
        bresp_d   = (w_state_d == W_RESP && w_err_d) ? RESP_SLVERR : RESP_OKAY;
    end

    // The RAM is addressed from the next-state index so a fresh word is ready one cycle after the index moves.
    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_wait_d  = r_wait_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            R_IDLE: if (ARVALID && arready_q) begin
                r_idx_d   = ARADDR[C_OFFSET_WIDTH-1:2];
                r_cnt_d   = ARLEN;
                r_wait_d  = 8'(READ_WAIT);
                r_state_d = R_WAIT;
            end
            R_WAIT: begin
                if (r_wait_q == 8'd0) r_state_d = R_READ;
                else                  r_wait_d  = r_wait_q - 8'd1;
            end
            R_READ: begin
                rdata_d   = ram_rdata;
                rlast_d   = (r_cnt_q == 8'd0);
                r_state_d = R_DATA;
            end
            R_DATA: if (RREADY && rvalid_q) begin
                if (rlast_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_idx_d   = r_idx_q + 1'b1;
                    r_cnt_d   = r_cnt_q - 8'd1;
                    r_state_d = R_READ;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_state_d != R_DATA) rlast_d = 1'b0;
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_wait_q  <= r_wait_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    axi_slave_ram #(
        .ADDR_WIDTH (IW),
        .DATA_WIDTH (C_AXI_DATA_WIDTH)
    ) u_ram (
        .clk   (ACLK),
        .we    (ram_we),
        .waddr (w_idx_q),
        .wstrb (WSTRB),
        .wdata (WDATA),
        .raddr (r_idx_d),
        .rdata (ram_rdata)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RDATA   = rdata_q;
    assign RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_memory.sv
// Randomised self-checking bench for axi_slave_memory against a word-array reference model.
module tb_axi_slave_memory;

    localparam int OW    = 12;
    localparam int DEPTH = 1 << (OW - 2);
    localparam int RW    = 0;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [31:0] wbuf  [256];
    logic [3:0]  sbuf  [256];
    logic [31:0] rbuf  [256];

    always #5 ACLK = ~ACLK;

    axi_slave_memory #(
        .C_AXI_DATA_WIDTH (32),
        .C_OFFSET_WIDTH   (OW),
        .READ_WAIT        (RW)
    ) dut (
        .ACLK (ACLK), .ARESETN (ARESETN),
        .AWADDR (AWADDR), .AWLEN (AWLEN), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
        .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .ARADDR (ARADDR), .ARLEN (ARLEN), .ARVALID (ARVALID), .ARREADY (ARREADY),
        .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST), .RVALID (RVALID), .RREADY (RREADY)
    );

    function automatic int widx(input logic [31:0] a, input int b);
        return (int'(a[OW-1:2]) + b) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len);
        for (int b = 0; b <= len; b++) begin
            int i;
            i = widx(addr, b);
            for (int k = 0; k < 4; k++)
                if (sbuf[b][k]) model[i][8*k +: 8] = wbuf[b][8*k +: 8];
            known[i] = known[i] | (sbuf[b] == 4'hF);
        end
    endtask

    // Called and returns on a falling edge; bad is the beat whose WLAST is inverted (-1 for none).
    task automatic axi_write(input logic [31:0] addr, input int len, input int bad,
                             output logic [1:0] resp);
        int g;
        resp = 2'bxx;
        AWADDR = addr; AWLEN = 8'(len); AWVALID = 1'b1;
        g = 0;
        while (!AWREADY && g < 100) begin @(negedge ACLK); g++; end
        if (!AWREADY) begin
            checks++; errors++; AWVALID = 1'b0;
            $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
            return;
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        for (int b = 0; b <= len; b++) begin
            WDATA = wbuf[b]; WSTRB = sbuf[b];
            WLAST = (b == len) ^ (b == bad);
            WVALID = 1'b1;
            g = 0;
            while (!WREADY && g < 100) begin @(negedge ACLK); g++; end
            if (!WREADY) begin
                checks++; errors++; WVALID = 1'b0;
                $display("FAIL w_timeout: beat %0d WREADY=%b required 1", b, WREADY);
                return;
            end
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        BREADY = 1'b1;
        g = 0;
        while (!BVALID && g < 100) begin @(negedge ACLK); g++; end
        if (!BVALID) begin
            checks++; errors++; BREADY = 1'b0;
            $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
            return;
        end
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0;
        checks++;
        if (BVALID !== 1'b0) begin
            errors++;
            $display("FAIL b_drop: BVALID=%b required 0", BVALID);
        end
        model_write(addr, len);
    endtask

    // Reads len+1 beats into rbuf; checks RLAST, stall hold and the post-burst idle.
    task automatic axi_read(input logic [31:0] addr, input int len, input bit stall,
                            output int lat);
        int g, b;
        bit tog, held, rr, held_last;
        logic [31:0] held_data;
        ARADDR = addr; ARLEN = 8'(len); ARVALID = 1'b1;
        g = 0; lat = -1;
        while (!ARREADY && g < 100) begin @(negedge ACLK); g++; end
        if (!ARREADY) begin
            checks++; errors++; ARVALID = 1'b0;
            $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
            return;
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        lat = 0;
        while (!RVALID && lat < 300) begin @(negedge ACLK); lat++; end
        if (!RVALID) begin
            checks++; errors++;
            $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
            return;
        end
        b = 0; tog = 1'b1; held = 1'b0; g = 0;
        held_data = '0; held_last = 1'b0;
        while (b <= len && g < 3000) begin
            rr = stall ? tog : 1'b1;
            tog = ~tog;
            RREADY = rr;
            if (RVALID) begin
                if (held) begin
                    checks++;
                    if (RDATA !== held_data || RLAST !== held_last) begin
                        errors++;
                        $display("FAIL r_hold: RDATA=%h RLAST=%b required %h %b",
                                 RDATA, RLAST, held_data, held_last);
                    end
                end
                if (rr) begin
                    rbuf[b] = RDATA;
                    checks++;
                    if (RLAST !== 1'(b == len)) begin
                        errors++;
                        $display("FAIL r_last: beat %0d RLAST=%b required %b", b, RLAST, b == len);
                    end
                    b++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; held_data = RDATA; held_last = RLAST;
                end
            end
            @(negedge ACLK);
            g++;
        end
        RREADY = 1'b0;
        checks++;
        if (b <= len || RVALID !== 1'b0) begin
            errors++;
            $display("FAIL r_end: beats=%0d RVALID=%b required %0d 0", b, RVALID, len + 1);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge ACLK);
        checks++;
        if ({AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP, RDATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: AWREADY=%b WREADY=%b BVALID=%b ARREADY=%b RVALID=%b RDATA=%h required all 0",
                     AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA);
        end
        ARESETN = 1'b1;
        #1;
        checks++;
        if ({AWREADY, ARREADY} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_early: AWREADY=%b ARREADY=%b required 0 0", AWREADY, ARREADY);
        end
        @(negedge ACLK);
        checks++;
        if ({AWREADY, ARREADY, WREADY} !== 3'b110) begin
            errors++;
            $display("FAIL reset_ready: AWREADY=%b ARREADY=%b WREADY=%b required 1 1 0",
                     AWREADY, ARREADY, WREADY);
        end
    endtask

    task automatic test_single();
        logic [1:0] resp;
        int lat;
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write(32'h100, 0, -1, resp);
        check_word("single_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h100, 0, 1'b0, lat);
        check_word("single_latency", lat, 2 + RW);
        check_word("single_rdata", rbuf[0], 32'hDEADBEEF);
    endtask

    task automatic test_burst_stall();
        logic [1:0] resp;
        int lat;
        for (int b = 0; b < 4; b++) begin wbuf[b] = b + 1; sbuf[b] = 4'hF; end
        axi_write(32'h200, 3, -1, resp);
        check_word("burst_bresp", {30'd0, resp}, 32'd0);
        axi_read(32'h200, 3, 1'b1, lat);
        for (int b = 0; b < 4; b++) check_word("burst_rdata", rbuf[b], b + 1);
    endtask

    task automatic test_strobe();
        logic [1:0] resp;
        int lat;
        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        axi_write(32'h300, 0, -1, resp);
        wbuf[0] = 32'h12345678; sbuf[0] = 4'b0101;
        axi_write(32'h300, 0, -1, resp);
        axi_read(32'h300, 0, 1'b0, lat);
        check_word("strobe_rdata", rbuf[0], 32'hFF34FF78);
    endtask

    task automatic test_wlast_error();
        logic [1:0] resp;
        int lat;
        wbuf[0] = 32'hA5A50001; wbuf[1] = 32'hA5A50002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(32'h340, 1, 0, resp);
        check_word("wlast_early_bresp", {30'd0, resp}, 32'd2);
        axi_read(32'h340, 1, 1'b0, lat);
        check_word("wlast_early_beat0", rbuf[0], 32'hA5A50001);
        check_word("wlast_early_beat1", rbuf[1], 32'hA5A50002);
        axi_write(32'h340, 1, -1, resp);
        check_word("wlast_ok_bresp", {30'd0, resp}, 32'd0);
        axi_write(32'h340, 1, 1, resp);
        check_word("wlast_missing_bresp", {30'd0, resp}, 32'd2);
    endtask

    task automatic test_wrap();
        logic [1:0] resp;
        int lat;
        wbuf[0] = 32'h0BAD0FFC; wbuf[1] = 32'h0BAD0000; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(32'hFFC, 1, -1, resp);
        axi_read(32'h000, 0, 1'b0, lat);
        check_word("wrap_word0", rbuf[0], 32'h0BAD0000);
        axi_read(32'hFFC, 1, 1'b0, lat);
        check_word("wrap_last", rbuf[0], 32'h0BAD0FFC);
        check_word("wrap_first", rbuf[1], 32'h0BAD0000);
    endtask

    task automatic test_concurrent();
        logic [1:0] resp;
        int lat;
        for (int b = 0; b < 3; b++) begin wbuf[b] = 32'hC0DE0000 + b; sbuf[b] = 4'hF; end
        fork
            axi_write(32'h500, 2, -1, resp);
            axi_read(32'h200, 3, 1'b0, lat);
        join
        check_word("conc_bresp", {30'd0, resp}, 32'd0);
        for (int b = 0; b < 4; b++) check_word("conc_rdata", rbuf[b], b + 1);
        axi_read(32'h500, 2, 1'b0, lat);
        for (int b = 0; b < 3; b++) check_word("conc_readback", rbuf[b], 32'hC0DE0000 + b);
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0] resp;
        int g, lat;
        for (int b = 0; b < 4; b++) begin wbuf[b] = 32'h40400000 + b; sbuf[b] = 4'hF; end
        axi_write(32'h400, 3, -1, resp);
        ARADDR = 32'h400; ARLEN = 8'd3; ARVALID = 1'b1;
        g = 0;
        while (!ARREADY && g < 100) begin @(negedge ACLK); g++; end
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        g = 0;
        while (!RVALID && g < 100) begin @(negedge ACLK); g++; end
        @(negedge ACLK);
        RREADY = 1'b0;
        g = 0;
        while (!RVALID && g < 100) begin @(negedge ACLK); g++; end
        check_word("midrst_beat2", RDATA, 32'h40400001);
        #2 ARESETN = 1'b0;
        #1;
        checks++;
        if ({RVALID, ARREADY, AWREADY, BVALID, RLAST, WREADY} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outputs: RVALID=%b ARREADY=%b AWREADY=%b BVALID=%b required all 0",
                     RVALID, ARREADY, AWREADY, BVALID);
        end
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({ARREADY, RVALID} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_release: ARREADY=%b RVALID=%b required 1 0", ARREADY, RVALID);
        end
        axi_read(32'h100, 0, 1'b0, lat);
        check_word("midrst_readback", rbuf[0], model[widx(32'h100, 0)]);
        check_word("midrst_kept", model[widx(32'h400, 3)], 32'h40400003);
        axi_read(32'h40C, 0, 1'b0, lat);
        check_word("midrst_ram_kept", rbuf[0], 32'h40400003);
    endtask

    task automatic test_random();
        logic [1:0] resp;
        logic [31:0] addrs[$];
        logic [31:0] a;
        int len, bad, lat, i;
        for (int n = 0; n < 60; n++) begin
            if (addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 32'hFFF);
                len = $urandom_range(0, 7);
                bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
                for (int b = 0; b <= len; b++) begin
                    wbuf[b] = $urandom;
                    sbuf[b] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
                end
                axi_write(a, len, bad, resp);
                check_word("rand_bresp", {30'd0, resp}, (bad >= 0) ? 32'd2 : 32'd0);
                addrs.push_back(a);
            end else begin
                a = addrs[$urandom_range(0, addrs.size() - 1)];
                len = $urandom_range(0, 7);
                axi_read(a, len, 1'($urandom_range(0, 1)), lat);
                check_word("rand_latency", lat, 2 + RW);
                for (int b = 0; b <= len; b++) begin
                    i = widx(a, b);
                    if (known[i]) check_word("rand_rdata", rbuf[b], model[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin model[i] = '0; known[i] = 1'b0; end
        test_reset();
        test_single();
        test_burst_stall();
        test_strobe();
        test_wlast_error();
        test_wrap();
        test_concurrent();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
